// File: rtl/dap_pkg.sv
// rtl/dap_pkg.sv - shared sizes and state encoding for the DAP shift sequencer
package dap_pkg;

  localparam int DAP_DATA_W = 32;
  localparam int DAP_LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } dap_state_e;

endpackage

// File: rtl/dap_shift_sequencer.sv
// rtl/dap_shift_sequencer.sv - LSB-first bit sequencer driven by baud generator strobes
// Launches bits on sclk_negedge, captures on sclk_sampling, returns one response word per command.
module dap_shift_sequencer
  import dap_pkg::*;
#(
  parameter int DATA_W = DAP_DATA_W,
  parameter int LEN_W  = DAP_LEN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_dir,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bclk_en,
  input  logic              sclk_negedge,
  input  logic              sclk_sampling,
  output logic              io_out,
  output logic              io_oe,
  input  logic              io_in
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  dap_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              dir_q, dir_d;
  logic              bclk_en_q, bclk_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;

  logic              last_bit;
  logic [DATA_W-1:0] rx_cap;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_rdata_d = rsp_rdata_q;
    idx_d       = idx_q;
    len_d       = len_q;
    dir_d       = dir_q;
    bclk_en_d   = bclk_en_q;
    rsp_valid_d = rsp_valid_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;

    last_bit = (idx_q == (len_q - LEN_W'(1)));
    rx_cap   = rx_q;
    if (dir_q) begin
      rx_cap[idx_q[IDX_W-1:0]] = io_in;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      bclk_en_d   = 1'b0;
      io_oe_d     = 1'b0;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            tx_d  = cmd_wdata;
            dir_d = cmd_dir;
            // Zero and out-of-range lengths both mean a full word, keeping every index below DATA_W.
            len_d = ((cmd_len == '0) || (cmd_len > FULL_LEN)) ? FULL_LEN : cmd_len;
            rx_d      = '0;
            idx_d     = '0;
            bclk_en_d = 1'b1;
            state_d   = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (sclk_negedge) begin
            io_out_d = tx_q[0];
            io_oe_d  = ~dir_q;
            state_d  = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_sampling) begin
            rx_d = rx_cap;
            if (last_bit) begin
              state_d     = ST_RESP;
              bclk_en_d   = 1'b0;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = rx_cap;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
          // A coincident sampling strobe has already advanced idx_d, so the next bit goes out.
          if (sclk_negedge && !(sclk_sampling && last_bit)) begin
            io_out_d = tx_q[idx_d[IDX_W-1:0]];
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_rdata_q <= '0;
      idx_q       <= '0;
      len_q       <= FULL_LEN;
      dir_q       <= 1'b0;
      bclk_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      io_out_q    <= 1'b0;
      io_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_rdata_q <= rsp_rdata_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      bclk_en_q   <= bclk_en_d;
      rsp_valid_q <= rsp_valid_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bclk_en   = bclk_en_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;

endmodule

// File: doc/dap_shift_sequencer.md
Name: dap_shift_sequencer

Overview:
- Bit-level sequencer for the DAP serial interface.
- Accepts a command of 1..32 bits to drive out or capture in, LSB first.
- Enables the baud generator, then uses its negedge strobe to launch each bit and its sampling strobe to capture each bit.
- Returns one response word per command.
- Sits between the SWD/JTAG protocol engines and the baud generator / GPIO pad.

Parameters:
- DATA_W, 32, width of command and response data; also the maximum bits per command.
- LEN_W, 6, width of cmd_len; value 0 encodes DATA_W bits.

Ports:
- clk  input  1  system clock; same domain as the baud generator strobes.
- resetn  input  1  synchronous active-low reset, sampled on posedge clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (IDLE only).
- cmd_len  input  LEN_W  number of bits; 0 means DATA_W.
- cmd_dir  input  1  0 = drive out, 1 = capture in.
- cmd_wdata  input  DATA_W  output bits, bit 0 sent first.
- abort  input  1  cancel the current command; highest priority after reset.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DATA_W  captured bits, bit 0 captured first; bits >= len read 0.
- bclk_en  output  1  enable request to the baud generator (drives its CEN bit).
- sclk_negedge  input  1  single-cycle strobe from the baud generator: launch point.
- sclk_sampling  input  1  single-cycle strobe from the baud generator: capture point.
- io_out  output  1  data to the pad.
- io_oe  output  1  pad output enable.
- io_in  input  1  data from the pad, already synchronised.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - State IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, bclk_en=0, io_out=0, io_oe=0.
  - Internal idx=0, tx=0, rx=0.
- States: IDLE, ALIGN, SHIFT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch tx=cmd_wdata, dir, len (0 becomes DATA_W), clear rx, idx=0.
  - Go to ALIGN; bclk_en=1 from the next cycle.
- ALIGN:
  - Strobes other than sclk_negedge are ignored (discards a sampling strobe left over from the generator start-up).
  - On sclk_negedge: io_out<=tx[0], io_oe<=~dir; go to SHIFT.
- SHIFT:
  - On sclk_sampling: if dir=1, rx[idx]<=io_in.
    - If idx==len-1, go to RESP: bclk_en<=0, rsp_valid<=1, rsp_rdata<=rx including this bit.
    - Otherwise idx<=idx+1.
  - On sclk_negedge (not the last bit): io_out<=tx[idx], using idx after any same-cycle increment.
  - Simultaneous negedge and sampling in one cycle: the sampling is processed first (capture bit idx, increment), then the negedge launches bit idx+1.
  - A negedge arriving after the final sampling is ignored, because the state is already RESP.
- RESP:
  - rsp_valid=1; rsp_rdata stable until rsp_valid&&rsp_ready.
  - On that handshake: IDLE, cmd_ready=1 in the following cycle.
  - For dir=0, rsp_rdata=0.
- Line parking: io_out and io_oe hold their last values through RESP and IDLE. They are only changed by the next command's first negedge, by abort, or by reset.
- Latency, from the launch of bit 0 to rsp_valid: exactly len baud periods (sampling strobes). No back-to-back overlap; bclk_en drops between commands.
- abort=1 in any state, next cycle:
  - State IDLE, bclk_en=0, io_oe=0, rsp_valid=0.
  - No response for the aborted command.
  - A cmd_valid in the same cycle as abort is not accepted.
- Width rules:
  - idx is LEN_W bits.
  - len==DATA_W is compared without overflow; LEN_W must hold DATA_W.
  - Indexing is always < DATA_W.

Decomposition:
- Shared package dap_pkg holds:
  - state encoding localparams (ST_IDLE, ST_ALIGN, ST_SHIFT, ST_RESP);
  - DAP_DATA_W=32 and DAP_LEN_W=6.
- No sub-module; a single FSM plus shift/capture registers.
- Instantiated alongside the baud generator and wired to its negedge/sampling outputs.

Test Plan:
- Reset with cmd_valid=1 held → all outputs at reset values, cmd_ready=1; after release, the command is accepted in the first cycle.
- cmd_len=8, dir=0, wdata=0xA5, strobe model with a 4-cycle period, negedge and sampling 2 cycles apart → io_out sequence 1,0,1,0,0,1,0,1 and io_oe=1; rsp_valid after the 8th sampling with rsp_rdata=0; bclk_en falls in the same cycle.
- cmd_len=0 (32 bits), dir=1, io_in driven from 0xDEADBEEF LSB first → rsp_rdata=0xDEADBEEF, io_oe=0 throughout.
- cmd_len=3, dir=1, io_in=1,1,0; rsp_ready held low for 5 cycles → rsp_rdata=0x3 stable, cmd_ready=0 until the handshake, then IDLE.
- negedge and sampling in the same cycle every period, dir=0, len=4, wdata=0x6 → captures do not corrupt the output order; io_out is 0,1,1,0.
- abort asserted mid-SHIFT at idx=5 of 16 → next cycle bclk_en=0, io_oe=0, no rsp_valid; a following command of len=1, wdata=1 completes normally.
